// File: rtl/g16_bus_arbiter_if.sv
// g16 shared-bus signal bundle: master-side request/grant group and slave-side group.
// The arbiter takes the arb view; masters and the slave use their own views.
interface g16_bus_arbiter_if #(
    parameter int NUM_MSTR = 4,
    parameter int ADDR_W   = 48,
    parameter int DATA_W   = 16
);
    logic [NUM_MSTR-1:0]        need;
    logic [NUM_MSTR-1:0]        YouGotIt;
    logic [NUM_MSTR*ADDR_W-1:0] addrM;
    logic [NUM_MSTR*DATA_W-1:0] DoutM;
    logic [DATA_W-1:0]          DinMast;
    logic [NUM_MSTR-1:0]        Clast_mstr;
    logic [ADDR_W-1:0]          Adr;
    logic [DATA_W-1:0]          dbus_in;
    logic [DATA_W-1:0]          dataOut;
    logic                       tarActive;
    logic                       Clast;

    modport arb (
        input  need, addrM, DoutM, dataOut, Clast,
        output YouGotIt, DinMast, Clast_mstr, Adr, dbus_in, tarActive
    );

    modport master (
        output need, addrM, DoutM,
        input  YouGotIt, DinMast, Clast_mstr
    );

    modport slave (
        input  Adr, dbus_in, tarActive,
        output dataOut, Clast
    );
endinterface

// File: rtl/g16_bus_arbiter.sv
// Round-robin arbiter and bus controller for the g16 shared bus:
// one grantee at a time, one turnaround cycle between grants, hold timeout.
module g16_bus_arbiter #(
    parameter  int NUM_MSTR  = 4,
    parameter  int ADDR_W    = 48,
    parameter  int DATA_W    = 16,
    parameter  int MAX_BEATS = 256,
    localparam int GW        = $clog2(NUM_MSTR),
    localparam int CW        = $clog2(MAX_BEATS)
) (
    input  logic              sysClk,
    input  logic              rst,
    g16_bus_arbiter_if.arb    bus,
    output logic [GW-1:0]     grant_id,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

    state_t              state;
    state_t              state_n;
    logic [GW-1:0]       ptr;
    logic [GW-1:0]       sel;
    logic [GW-1:0]       idx;
    logic                found;
    logic [CW-1:0]       cnt;
    logic                done;
    logic                tmo_n;
    logic [NUM_MSTR-1:0] gnt;
    logic                tar;
    logic                busy;

    // First requester at or above the round-robin pointer, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_MSTR; k++) begin
            idx = GW'((32'(ptr) + k) % NUM_MSTR);
            if (!found && bus.need[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            IDLE, TURN: state_n = found ? BUSY : IDLE;
            BUSY: begin
                if (bus.Clast) begin
                    done = 1'b1;
                end else if (!bus.need[grant_id]) begin
                    done = 1'b1;
                end else if (cnt == CW'(MAX_BEATS - 1)) begin
                    done  = 1'b1;
                    tmo_n = 1'b1;
                end
                if (done) state_n = TURN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (!rst) begin
            state       <= IDLE;
            gnt         <= '0;
            tar         <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            timeout_err <= tmo_n;
            if (state != BUSY) begin
                if (found) begin
                    gnt      <= NUM_MSTR'(1) << sel;
                    tar      <= 1'b1;
                    grant_id <= sel;
                    ptr      <= (sel == GW'(NUM_MSTR - 1)) ? '0 : sel + 1'b1;
                    cnt      <= '0;
                end
            end else if (done) begin
                gnt <= '0;
                tar <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy           = (state == BUSY);
    assign bus.YouGotIt   = gnt;
    assign bus.tarActive  = tar;
    assign bus.Adr        = busy ? bus.addrM[int'(grant_id)*ADDR_W +: ADDR_W] : '0;
    assign bus.dbus_in    = busy ? bus.DoutM[int'(grant_id)*DATA_W +: DATA_W] : '0;
    assign bus.DinMast    = busy ? bus.dataOut : '0;
    assign bus.Clast_mstr = busy ? (gnt & {NUM_MSTR{bus.Clast}}) : '0;

endmodule

// File: tb/tb_g16_bus_arbiter.sv
// Randomized scoreboard bench for g16_bus_arbiter against a transaction-level
// model of ownership, round-robin priority and hold limit.
module tb_g16_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 16;
    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       timeout_err;

    always #5 clk = ~clk;

    g16_bus_arbiter_if #(.NUM_MSTR(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    g16_bus_arbiter #(
        .NUM_MSTR(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB)
    ) dut (
        .sysClk(clk),
        .rst(rst),
        .bus(bus),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [N-1:0]  ygi;
        logic          tar;
        logic [1:0]    gid;
        logic          tmo;
        logic [AW-1:0] adr;
        logic [DW-1:0] dbus;
        logic [DW-1:0] din;
        logic [N-1:0]  clm;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: who owns the bus (-1 none), beats held, next priority, last grantee.
    int   owner;
    int   beats;
    int   prio;
    int   gid;
    bit   tmo;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("YouGotIt", 64'(bus.YouGotIt), 64'(e.ygi));
                chk("tarActive", 64'(bus.tarActive), 64'(e.tar));
                chk("grant_id", 64'(grant_id), 64'(e.gid));
                chk("timeout_err", 64'(timeout_err), 64'(e.tmo));
                chk("Adr", 64'(bus.Adr), 64'(e.adr));
                chk("dbus_in", 64'(bus.dbus_in), 64'(e.dbus));
                chk("DinMast", 64'(bus.DinMast), 64'(e.din));
                chk("Clast_mstr", 64'(bus.Clast_mstr), 64'(e.clm));
                chk("onehot", 64'($onehot0(bus.YouGotIt)), 64'd1);
                chk("tar_vs_grant", 64'(bus.tarActive), 64'(|bus.YouGotIt));
            end
        end
    end

    initial begin
        exp_t    e;
        int      ph;
        int      c;
        bit      hit;
        bit      ntmo;
        rst         = 1'b0;
        bus.need    = '0;
        bus.addrM   = '0;
        bus.DoutM   = '0;
        bus.dataOut = '0;
        bus.Clast   = 1'b0;
        @(posedge clk);
        #1;
        owner = -1;
        beats = 0;
        prio  = 0;
        gid   = 0;
        tmo   = 1'b0;

        for (int cyc = 0; cyc < 2400; cyc++) begin
            ph  = (cyc / 300) % 4;
            rst = !(cyc < 2 || $urandom_range(0, 79) == 0);
            case (ph)
                0: begin
                    for (int b = 0; b < N; b++)
                        if ($urandom_range(0, 4) == 0) bus.need[b] = ~bus.need[b];
                    bus.Clast = ($urandom_range(0, 3) == 0);
                end
                1: begin
                    bus.need  = '1;
                    bus.Clast = ($urandom_range(0, 1) == 0);
                end
                2: begin
                    bus.need = 4'($urandom);
                    if (owner >= 0) bus.need[owner] = 1'b1;
                    bus.Clast = (beats == MB - 1) && ($urandom_range(0, 1) == 0);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0)
                        bus.need = 4'(1) << $urandom_range(0, 3);
                    else
                        bus.need = bus.need & 4'($urandom);
                    bus.Clast = ($urandom_range(0, 9) < 3);
                end
            endcase
            for (int m = 0; m < N; m++) begin
                bus.addrM[m*AW +: AW] = AW'({$urandom, $urandom});
                bus.DoutM[m*DW +: DW] = DW'($urandom);
            end
            bus.dataOut = DW'($urandom);

            e.ygi  = (owner >= 0) ? (4'(1) << owner) : '0;
            e.tar  = (owner >= 0);
            e.gid  = 2'(gid);
            e.tmo  = tmo;
            e.adr  = (owner >= 0) ? bus.addrM[owner*AW +: AW] : '0;
            e.dbus = (owner >= 0) ? bus.DoutM[owner*DW +: DW] : '0;
            e.din  = (owner >= 0) ? bus.dataOut : '0;
            e.clm  = (owner >= 0 && bus.Clast) ? e.ygi : '0;
            q.push_back(e);

            ntmo = 1'b0;
            if (!rst) begin
                owner = -1;
                beats = 0;
                prio  = 0;
                gid   = 0;
            end else if (owner >= 0) begin
                if (bus.Clast || !bus.need[owner]) begin
                    owner = -1;
                end else if (beats == MB - 1) begin
                    owner = -1;
                    ntmo  = 1'b1;
                end else begin
                    beats++;
                end
            end else begin
                hit = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (prio + k) % N;
                    if (!hit && bus.need[c]) begin
                        hit   = 1'b1;
                        owner = c;
                        gid   = c;
                        prio  = (c + 1) % N;
                        beats = 0;
                    end
                end
            end
            tmo = ntmo;

            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/g16_bus_arbiter.md
Name: g16_bus_arbiter

Overview:
Round-robin arbiter and bus controller for the g16 shared bus. It accepts bus requests from NUM_MSTR masters, grants the bus to exactly one master at a time, and steers that master's address and write data onto the slave side while asserting tarActive. Read data and the slave's Clast go back to the granted master only. The block sits between the master-side and slave-side g16 signal groups, and enforces transaction termination, a turnaround cycle and a hold timeout.

Parameters:
NUM_MSTR, 4, number of requesting masters (2..8)
ADDR_W, 48, address width
DATA_W, 16, data width
MAX_BEATS, 256, maximum cycles one grant may stay in BUSY before a forced release

Ports:
sysClk  in  1  system clock; all state on rising edge
rst  in  1  synchronous reset, active-low
need  in  NUM_MSTR  per-master bus request
YouGotIt  out  NUM_MSTR  one-hot grant (registered)
addrM  in  NUM_MSTR*ADDR_W  packed master addresses; master i at [i*ADDR_W +: ADDR_W]
DoutM  in  NUM_MSTR*DATA_W  packed master write data
DinMast  out  DATA_W  read data to masters
Clast_mstr  out  NUM_MSTR  per-master end-of-transaction indication
Adr  out  ADDR_W  address to slave
dbus_in  out  DATA_W  write data to slave
dataOut  in  DATA_W  read data from slave
tarActive  out  1  slave select / transaction active (registered)
Clast  in  1  last-beat indication from slave
grant_id  out  $clog2(NUM_MSTR)  index of current/last grantee
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Synchronous active-low reset. When rst is low at a rising edge:
  - state=IDLE, YouGotIt=0, tarActive=0, grant_id=0, timeout_err=0
  - RR pointer set so master 0 has highest priority; beat counter=0.
- FSM states: IDLE, BUSY, TURN.
- IDLE:
  - If need!=0, select the first requester searching from ptr upward mod NUM_MSTR.
  - At the edge: YouGotIt[sel]=1, grant_id=sel, tarActive=1, state=BUSY, ptr=(sel+1) mod NUM_MSTR.
  - Latency: need high in cycle c gives YouGotIt high in cycle c+1.
  - If need==0, stay in IDLE.
- BUSY (granted master g):
  - Adr=addrM[g], dbus_in=DoutM[g] (combinational mux).
  - DinMast=dataOut.
  - Clast_mstr[g]=Clast; all other Clast_mstr bits=0.
  - Beat counter increments each BUSY cycle.
  - Clast=1 sampled: next state TURN. This is normal completion.
  - need[g]=0 sampled without Clast: next state TURN (master abort, no error).
  - Counter reaches MAX_BEATS-1 without Clast: next state TURN, timeout_err=1 for one cycle (the first TURN cycle).
  - Clast and timeout in the same cycle: Clast wins, no timeout_err.
- TURN:
  - Exactly one cycle with YouGotIt=0, tarActive=0, Adr=0, dbus_in=0, DinMast=0, Clast_mstr=0.
  - Arbitrates the same way as IDLE, so a pending request is granted at the end of TURN; otherwise go to IDLE.
  - The minimum gap between back-to-back grants is 1 dead cycle.
- Outside BUSY:
  - Adr, dbus_in, DinMast and Clast_mstr are 0.
  - Clast is ignored.
  - grant_id holds the last grantee.
- Invariants:
  - YouGotIt is at most one-hot.
  - tarActive==|YouGotIt.
  - need changes on non-granted masters never affect the current grant.
- Reset mid-BUSY: at the next edge all outputs are idle. No TURN cycle and no timeout_err.
- Beat counter width is $clog2(MAX_BEATS). It is cleared on each grant and never wraps within a grant.

Test Plan:
- Single request: need=4'b0100 from cycle 2, Adr driven from master 2 = 48'h0000_1234_5678, Clast at the 4th BUSY cycle -> YouGotIt=4'b0100 in cycle 3, Adr=48'h0000_1234_5678 while tarActive=1, Clast_mstr=4'b0100 with Clast, TURN cycle with all outputs 0, then IDLE.
- Round-robin fairness: need=4'b1111 held, each transaction 2 beats -> grant order 0,1,2,3,0, each grant separated by exactly 1 TURN cycle, grant_id sequence 0,1,2,3,0.
- Data steering: master 1 DoutM=16'hBEEF, master 3 DoutM=16'hCAFE, slave dataOut=16'h5A5A, grant to 3 -> dbus_in=16'hCAFE and DinMast=16'h5A5A, Clast_mstr[1]=0 throughout.
- Timeout: MAX_BEATS=8, master 0 holds need and Clast is never asserted -> BUSY for 8 cycles, timeout_err pulses once in the TURN cycle, next requester is granted after it.
- Abort and collision: master 2 drops need in BUSY cycle 3 -> TURN next cycle with no timeout_err. Separately, Clast and timeout in the same cycle -> TURN with timeout_err=0.
- Reset mid-transaction: rst=0 for one cycle during BUSY -> next cycle YouGotIt=0, tarActive=0, grant_id=0, no timeout_err. With need=4'b1010 afterwards -> master 1 is granted first (pointer reset).
